// File: rtl/mod_symbol_scheduler.sv
// Symbol scheduler for the configurable digital modulator: takes bytes over valid/ready,
// serialises them MSB-first at a fixed symbol rate and keys two internal carrier tones by mode.
module mod_symbol_scheduler #(
  parameter int DIV0     = 250,
  parameter int DIV1     = 125,
  parameter int SYM_CLKS = 5000,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mod_out,
  output logic              busy,
  output logic              sym_bit,
  output logic              sym_strobe,
  output logic              frame_done
);

  localparam int SYM_W = (SYM_CLKS > 1) ? $clog2(SYM_CLKS) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int C0_W  = (DIV0 > 1) ? $clog2(DIV0) : 1;
  localparam int C1_W  = (DIV1 > 1) ? $clog2(DIV1) : 1;

  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_CLKS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [C0_W-1:0]  C0_LAST  = C0_W'(DIV0 - 1);
  localparam logic [C1_W-1:0]  C1_LAST  = C1_W'(DIV1 - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_BASK = 2'b00,
    MODE_BPSK = 2'b01,
    MODE_BFSK = 2'b10,
    MODE_OFF  = 2'b11
  } mode_t;

  state_t             state, state_nxt;
  mode_t              mode_l;
  logic [DATA_W-1:0]  shreg;
  logic [BIT_W-1:0]   bit_idx;
  logic [SYM_W-1:0]   sym_cnt;
  logic [C0_W-1:0]    cnt0;
  logic [C1_W-1:0]    cnt1;
  logic               ph0, ph1;

  logic               cur_bit;
  logic               sym_end;
  logic               word_end;
  logic               mode_ok;
  logic               xfer;
  logic               m;

  assign cur_bit  = shreg[DATA_W-1];
  assign sym_end  = (sym_cnt == SYM_LAST);
  assign word_end = sym_end && (bit_idx == '0);
  assign mode_ok  = (mode_t'(mode) != MODE_OFF);

  // Next-state, handshake and pre-output keying.
  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    xfer      = 1'b0;
    m         = 1'b0;
    case (state)
      IDLE: begin
        s_ready = mode_ok;
        xfer    = s_valid && s_ready;
        if (xfer) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        s_ready = mode_ok && word_end;
        xfer    = s_valid && s_ready;
        if (word_end && !xfer) state_nxt = IDLE;
        case (mode_l)
          MODE_BASK: m = cur_bit ? ph0 : 1'b0;
          MODE_BPSK: m = cur_bit ? ph0 : ~ph0;
          MODE_BFSK: m = cur_bit ? ph1 : ph0;
          default:   m = 1'b0;
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Serialiser and carrier datapath.
  // NOTE: every datapath register is reset here because frames must restart from a known phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_l  <= MODE_BASK;
      shreg   <= '0;
      bit_idx <= '0;
      sym_cnt <= '0;
      cnt0    <= '0;
      cnt1    <= '0;
      ph0     <= 1'b0;
      ph1     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            shreg   <= s_data;
            bit_idx <= BIT_LAST;
            sym_cnt <= '0;
            mode_l  <= mode_t'(mode);
            cnt0    <= '0;
            cnt1    <= '0;
            ph0     <= 1'b0;
            ph1     <= 1'b0;
          end
        end
        ACTIVE: begin
          // Carriers free-run across word boundaries so back-to-back frames stay phase-continuous.
          if (cnt0 == C0_LAST) begin
            cnt0 <= '0;
            ph0  <= ~ph0;
          end else begin
            cnt0 <= cnt0 + C0_W'(1);
          end
          if (cnt1 == C1_LAST) begin
            cnt1 <= '0;
            ph1  <= ~ph1;
          end else begin
            cnt1 <= cnt1 + C1_W'(1);
          end

          if (sym_end) begin
            sym_cnt <= '0;
            if (bit_idx != '0) begin
              bit_idx <= bit_idx - BIT_W'(1);
              shreg   <= shreg << 1;
            end else if (xfer) begin
              shreg   <= s_data;
              bit_idx <= BIT_LAST;
              mode_l  <= mode_t'(mode);
            end
          end else begin
            sym_cnt <= sym_cnt + SYM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: one clk behind internal state so strobes align with the last output clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mod_out    <= 1'b0;
      busy       <= 1'b0;
      sym_bit    <= 1'b0;
      sym_strobe <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mod_out    <= m;
      busy       <= (state == ACTIVE);
      sym_bit    <= (state == ACTIVE) && cur_bit;
      sym_strobe <= (state == ACTIVE) && sym_end;
      frame_done <= (state == ACTIVE) && word_end;
    end
  end

endmodule

// File: tb/tb_mod_symbol_scheduler.sv
// Scoreboard bench for mod_symbol_scheduler: stimulus pushes the expected per-clk output
// trace of each word, a negedge monitor pops and compares while busy is presented.
module tb_mod_symbol_scheduler;

  localparam int DIV0  = 4;
  localparam int DIV1  = 2;
  localparam int SYM   = 16;
  localparam int DW    = 8;
  localparam int FRAME = SYM * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready, mod_out, busy, sym_bit, sym_strobe, frame_done;

  typedef struct packed {
    logic mod_out;
    logic busy;
    logic sym_bit;
    logic sym_strobe;
    logic frame_done;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_busy = 1'b0;

  mod_symbol_scheduler #(
    .DIV0(DIV0), .DIV1(DIV1), .SYM_CLKS(SYM), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .mod_out(mod_out), .busy(busy), .sym_bit(sym_bit),
    .sym_strobe(sym_strobe), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Expected trace of one word: carrier time t counts clks since the carrier was last zeroed.
  task automatic push_word(input logic [DW-1:0] w, input logic [1:0] md, input int t0);
    int   t;
    logic b, p0, p1, m;
    obs_t e;
    for (int k = 0; k < FRAME; k++) begin
      t  = t0 + k;
      b  = w[DW-1-(k/SYM)];
      p0 = ((t / DIV0) % 2) == 1;
      p1 = ((t / DIV1) % 2) == 1;
      case (md)
        2'b00:   m = b ? p0 : 1'b0;
        2'b01:   m = b ? p0 : ~p0;
        2'b10:   m = b ? p1 : p0;
        default: m = 1'b0;
      endcase
      e.mod_out    = m;
      e.busy       = 1'b1;
      e.sym_bit    = b;
      e.sym_strobe = (k % SYM) == SYM - 1;
      e.frame_done = (k == FRAME - 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compares every busy output clk against the scoreboard, checks quiet idle outputs.
  always @(negedge clk) begin
    if (rst) begin
      prev_busy <= 1'b0;
    end else begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_output @%0t: busy=1 with no expected word", $time);
        end else begin
          check("out{mod,busy,bit,strb,fd}",
                32'({mod_out, busy, sym_bit, sym_strobe, frame_done}),
                32'(exp_q.pop_front()));
        end
      end else begin
        if (prev_busy && exp_q.size() != 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL busy_gap @%0t: busy fell with %0d outputs still expected", $time, exp_q.size());
        end
        check("idle{mod,bit,strb,fd}", 32'({mod_out, sym_bit, sym_strobe, frame_done}), 32'd0);
      end
      prev_busy <= busy;
    end
  end

  // Called at a negedge; transfer happens on the following posedge.
  task automatic send(input logic [DW-1:0] w, input logic [1:0] md, input int t0);
    mode    = md;
    s_data  = w;
    s_valid = 1'b1;
    #1;
    check("s_ready_at_send", 32'(s_ready), 32'd1);
    push_word(w, md, t0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = ~w;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hits;
    int pos;
    rst     = 1'b1;
    mode    = 2'b00;
    s_data  = '0;
    s_valid = 1'b0;

    // 1. Reset state and mode=11 acceptance block.
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({mod_out, busy, sym_bit, sym_strobe, frame_done}), 32'd0);
    check("reset_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_s_ready_mode00", 32'(s_ready), 32'd1);
    mode    = 2'b11;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    #1;
    check("idle_s_ready_mode11", 32'(s_ready), 32'd0);
    repeat (4) @(negedge clk);
    check("no_accept_mode11", 32'(busy), 32'd0);
    s_valid = 1'b0;
    mode    = 2'b00;
    @(negedge clk);

    // 2. BASK 0xA5; mode=11 mid-frame neither aborts nor allows a follow-on transfer.
    send(8'hA5, 2'b00, 0);
    repeat (60) @(negedge clk);
    mode    = 2'b11;
    s_valid = 1'b1;
    s_data  = 8'h33;
    #1;
    check("s_ready_mid_frame", 32'(s_ready), 32'd0);
    wait_drain("bask_a5", 4 * FRAME);
    check("s_ready_after_mode11", 32'(s_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("no_b2b_mode11", 32'(busy), 32'd0);
    s_valid = 1'b0;
    mode    = 2'b00;
    #1;
    check("idle_s_ready_after_a5", 32'(s_ready), 32'd1);
    @(negedge clk);

    // 3. BPSK 0x0F, 4. BFSK 0x80.
    send(8'h0F, 2'b01, 0);
    wait_drain("bpsk_0f", 4 * FRAME);
    send(8'h80, 2'b10, 0);
    wait_drain("bfsk_80", 4 * FRAME);

    // 5. Back-to-back 0xFF then 0x00 with s_valid held high.
    mode    = 2'b00;
    s_data  = 8'hFF;
    s_valid = 1'b1;
    #1;
    check("b2b_s_ready_first", 32'(s_ready), 32'd1);
    push_word(8'hFF, 2'b00, 0);
    @(posedge clk);
    #1;
    s_data = 8'h00;
    hits = 0;
    pos  = -1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      #1;
      if (s_ready) begin
        hits++;
        pos = i;
      end
    end
    push_word(8'h00, 2'b00, FRAME);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("b2b_s_ready_pulses", 32'(hits), 32'd1);
    check("b2b_s_ready_clk", 32'(pos), 32'(FRAME - 1));
    @(negedge clk);
    check("b2b_second_word_busy_s_ready", 32'(s_ready), 32'd0);
    wait_drain("b2b", 6 * FRAME);

    // 6. Mode change mid-frame is ignored; async reset mid-frame clears outputs at once.
    send(8'hFF, 2'b00, 0);
    repeat (40) @(negedge clk);
    mode = 2'b01;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'({mod_out, busy, sym_bit, sym_strobe, frame_done}), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("s_ready_after_reset", 32'(s_ready), 32'd1);
    @(negedge clk);
    send(8'hFF, 2'b00, 0);
    wait_drain("post_reset", 4 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_symbol_scheduler.md
Name: mod_symbol_scheduler

Overview:
- Sequences the modulator datapath for the configurable digital modulator.
- Accepts data bytes over a valid/ready handshake and serialises them MSB-first at a fixed symbol rate.
- Generates two carrier tones internally (f0 = clk/(2*DIV0), f1 = clk/(2*DIV1)) and selects or gates them per bit according to the latched mode (BASK/BPSK/BFSK).
- Sits between the byte source and the modulator output pin.

Parameters:
- DIV0, 250, half-period of carrier tone 0 in clk cycles (100 kHz at 50 MHz); must be >= 2.
- DIV1, 125, half-period of carrier tone 1 in clk cycles (BFSK "1" tone, 200 kHz); must be >= 1.
- SYM_CLKS, 5000, clk cycles per symbol (10 tone-0 periods); must be >= 2.
- DATA_W, 8, bits per accepted word.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- mode  in  2  00 BASK, 01 BPSK, 10 BFSK, 11 disabled
- s_data  in  DATA_W  word to transmit
- s_valid  in  1  s_data valid
- s_ready  out  1  block will accept s_data this cycle
- mod_out  out  1  modulated output, registered
- busy  out  1  high while a word is being transmitted
- sym_bit  out  1  bit currently being transmitted
- sym_strobe  out  1  1-clk pulse on the last clk of each symbol
- frame_done  out  1  1-clk pulse on the last clk of each word's final symbol

Behaviour:
- Reset (async):
  - All outputs are 0 except s_ready, which follows its combinational rule.
  - FSM enters IDLE; counters, phases and shift register clear to 0.
  - mod_out drops to 0 immediately, including when reset is asserted mid-frame.
- FSM has two states, IDLE and ACTIVE.
- s_ready = (mode != 11) AND (IDLE OR (ACTIVE AND last bit AND sym_cnt == SYM_CLKS-1)).
- Transfer occurs on a clk edge with s_valid && s_ready.
- IDLE → ACTIVE on transfer. At that edge:
  - shift register ← s_data; bit_idx ← DATA_W-1; sym_cnt ← 0.
  - Both carrier counters ← 0 and both phases ← 0, so every frame starts at phase 0.
  - mode is latched.
- ACTIVE:
  - sym_cnt increments each clk and wraps at SYM_CLKS-1.
  - On wrap, sym_strobe = 1. If bit_idx > 0, bit_idx decrements and the shift register advances to the next bit.
- End of a word (wrap with bit_idx == 0): frame_done = 1 on that clk.
  - Transfer on the same edge (back-to-back): load the new word, relatch mode, stay ACTIVE. Carrier counters and phases are NOT reset, so phase is continuous.
  - No transfer: → IDLE.
- Carrier generation (free-running while ACTIVE):
  - cnt0 counts 0..DIV0-1; on DIV0-1 it wraps and toggles ph0.
  - cnt1 / ph1 work the same way with DIV1.
- Combinational pre-output m, with b = current bit:
  - BASK: b ? ph0 : 0
  - BPSK: b ? ph0 : ~ph0
  - BFSK: b ? ph1 : ph0
  - In IDLE, m = 0.
- mod_out, busy and sym_bit are registered versions of m / (state==ACTIVE) / b. They lag internal state by exactly 1 clk, i.e. they are first valid 1 clk after the transfer edge.
- sym_strobe and frame_done are registered with the same 1-clk lag, so the pulses align with the last output clk of the symbol.
- mode changes while ACTIVE are ignored until the next transfer.
- mode = 11 in IDLE blocks acceptance. mode = 11 arriving mid-frame does not abort the frame.
- s_data is sampled only on the transfer edge and may change at any other time.

Test Plan:
(DIV0=4, DIV1=2, SYM_CLKS=16, DATA_W=8 unless stated.)
1. Reset, then release with mode=00 and s_valid=0 → mod_out=busy=sym_bit=sym_strobe=frame_done=0, s_ready=1; with mode=11 → s_ready=0.
2. BASK, single-cycle transfer of 0xA5 →
   - busy high for exactly 128 clks.
   - sym_bit sequence 1,0,1,0,0,1,0,1, each 16 clks.
   - mod_out is period 8 (4 low, 4 high, starting low) during 1-bits and 0 during 0-bits.
   - 8 sym_strobe pulses; frame_done pulses once on output clk 128.
   - Returns to IDLE with s_ready=1.
3. BPSK, 0x0F → first 64 clks mod_out = 1,1,1,1,0,0,0,0 repeating (inverted carrier); last 64 clks 0,0,0,0,1,1,1,1 repeating.
4. BFSK, 0x80 → first symbol mod_out period 4 (2 low / 2 high); remaining 7 symbols period 8.
5. s_valid held high, 0xFF then 0x00, BASK →
   - s_ready high only at transfer 1 and for exactly 1 clk at internal clk 127.
   - busy continuously high for 256 clks with no gap.
   - Carrier at the word boundary continues without phase reset.
   - 2 frame_done pulses.
6. Mid-frame disturbances →
   - mode switched 00→01 at clk 40 of a 0xFF frame: waveform stays BASK for the whole frame.
   - rst asserted at clk 50: all outputs 0 in the same cycle (async); after release, s_ready=1 and the next transfer starts at phase 0.
